// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use / branch-operand interlocks, cache-miss freeze FSM,
// miss watchdog and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int           INSTR_W      = 16,
  parameter int           REG_W        = 4,
  parameter logic [3:0]   OP_LOAD      = 4'b1000,
  parameter logic [3:0]   OP_STORE     = 4'b1001,
  parameter logic [3:0]   OP_B         = 4'b1100,
  parameter logic [3:0]   OP_BR        = 4'b1101,
  parameter int           MISS_TIMEOUT = 255,
  parameter int           CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic [REG_W-1:0]   mem_rd,
  input  logic               ex_regwrite,
  input  logic               mem_regwrite,
  input  logic               branch_taken,
  input  logic               icache_miss,
  input  logic               dcache_miss,
  output logic               stall_fe,
  output logic               bubble_ex,
  output logic               freeze_be,
  output logic               flush_ifid,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // state | meaning
  // RUN   | no cache miss outstanding, hazard interlocks active
  // DMISS | D-cache fill in progress, back end frozen
  // IMISS | I-cache fill in progress, front end stalled, back end drains
  typedef enum logic [1:0] {S_RUN, S_DMISS, S_IMISS} state_t;

  localparam int TMR_W = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MISS_TIMEOUT);

  state_t             r_state;
  state_t             w_next_state;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               r_err;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic [3:0] w_id_op, w_ex_op, w_mem_op;
  logic       w_lu, w_brh, w_is_branch;
  logic       w_unused;

  assign w_id_op  = id_instr[INSTR_W-1 -: 4];
  assign w_ex_op  = ex_instr[INSTR_W-1 -: 4];
  assign w_mem_op = mem_instr[INSTR_W-1 -: 4];

  // A store's rt is data, forwarded MEM->MEM, so it never interlocks on a load
  assign w_lu = (w_ex_op == OP_LOAD) && (ex_rd != '0) &&
                ((ex_rd == id_rs) || ((w_id_op != OP_STORE) && (ex_rd == id_rt)));

  assign w_brh = (w_id_op == OP_BR) &&
                 ((ex_regwrite && (ex_rd != '0) && (ex_rd == id_rs)) ||
                  ((w_mem_op == OP_LOAD) && (mem_rd != '0) && (mem_rd == id_rs)));

  assign w_is_branch = (w_id_op == OP_B) || (w_id_op == OP_BR);

  assign w_unused = ^{mem_regwrite, id_instr[INSTR_W-5:0],
                      ex_instr[INSTR_W-5:0], mem_instr[INSTR_W-5:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_RUN;
    stall_fe     = 1'b0;
    bubble_ex    = 1'b0;
    freeze_be    = 1'b0;
    flush_ifid   = 1'b0;
    if (dcache_miss)      w_next_state = S_DMISS;
    else if (icache_miss) w_next_state = S_IMISS;

    if (dcache_miss) begin
      freeze_be = 1'b1;
      stall_fe  = 1'b1;
    end else if (icache_miss) begin
      stall_fe  = 1'b1;
      bubble_ex = 1'b1;
    end else if (w_lu || w_brh) begin
      stall_fe  = 1'b1;
      bubble_ex = 1'b1;
    end else if (w_is_branch && branch_taken) begin
      flush_ifid = 1'b1;
    end
  end

  always_comb begin
    w_timer_nxt = r_timer;
    if (w_next_state != r_state)
      w_timer_nxt = '0;
    else if ((r_state != S_RUN) && (r_timer != TMR_MAX))
      w_timer_nxt = r_timer + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      if ((MISS_TIMEOUT != 0) && (w_timer_nxt == TMR_MAX))
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_fe && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_ifid && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign err_timeout = r_err;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
